// File: rtl/adc_pipe_pkg.sv
// adc_pipe_pkg -- shared state type and default parameters for the ADC decimator.
// Rev 1.0
`default_nettype none

package adc_pipe_pkg;

  localparam int unsigned CODE_W           = 3;
  localparam int unsigned OSR_LOG2_DEFAULT = 3;
  localparam int unsigned WARMUP_DEFAULT   = 2;
  localparam int unsigned DEPTH_DEFAULT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ACCUM  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/adc_pipe_sync_fifo.sv
// adc_pipe_sync_fifo -- single-clock FIFO with registered head word, level and empty/full.
// Rev 1.0
`default_nettype none

module adc_pipe_sync_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pop_ok_w;
  logic             push_ok_w;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));

  always_comb begin
    pop_ok_w  = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves on the same edge.
    push_ok_w = push_i && (!full_o || pop_ok_w);
    wr_d      = push_ok_w ? wr_q + PTR_W'(1) : wr_q;
    rd_d      = pop_ok_w ? rd_q + PTR_W'(1) : rd_q;
    level_d   = level_q;
    if (push_ok_w && !pop_ok_w) level_d = level_q + LVL_W'(1);
    if (!push_ok_w && pop_ok_w) level_d = level_q - LVL_W'(1);
    // The new head may be the word being written right now.
    if (level_d == '0)                rdata_d = '0;
    else if (push_ok_w && wr_q == rd_d) rdata_d = wdata_i;
    else                              rdata_d = mem_q[rd_d];
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_w) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/adc_pipe_decimator.sv
// adc_pipe_decimator -- sums blocks of 2^OSR_LOG2 encoder codes into an output FIFO.
// Rev 1.0
`default_nettype none

module adc_pipe_decimator
  import adc_pipe_pkg::*;
#(
  parameter int unsigned OSR_LOG2 = OSR_LOG2_DEFAULT,
  parameter int unsigned WARMUP   = WARMUP_DEFAULT,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
  input  logic                        clock_i,
  input  logic                        reset_ni,
  input  logic                        enable_i,
  input  logic [CODE_W-1:0]           d_i,
  output logic [CODE_W+OSR_LOG2-1:0]  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  input  logic                        clear_ovf_i
);

  localparam int unsigned SUM_W  = CODE_W + OSR_LOG2;
  localparam int unsigned CNT_W  = OSR_LOG2;
  localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = '1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = (WARMUP >= 2) ? WCNT_W'(WARMUP - 2) : '0;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [SUM_W-1:0]  acc_q;
  logic              ovf_q, ovf_d;

  logic              push_w;
  logic [SUM_W-1:0]  sum_w;
  logic              full_w;
  logic              empty_w;
  logic              drop_w;

  assign sum_w  = acc_q + SUM_W'(d_i);
  assign push_w = (state_q == ST_ACCUM) && enable_i && (cnt_q == CNT_LAST);
  assign drop_w = push_w && full_w && !(ready_i && !empty_w);

  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf_i) ovf_d = 1'b0;
    if (drop_w)      ovf_d = 1'b1;
  end

  // The code seen on the enabling edge is the first of the WARMUP discarded codes.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (!enable_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        wcnt_q  <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            wcnt_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            if (WARMUP >= 2) begin
              state_q <= ST_WARMUP;
            end else begin
              state_q <= ST_ACCUM;
              if (WARMUP == 0) begin
                acc_q <= SUM_W'(d_i);
                cnt_q <= CNT_W'(1);
              end
            end
          end
          ST_WARMUP: begin
            if (wcnt_q == WCNT_LAST) state_q <= ST_ACCUM;
            else                     wcnt_q  <= wcnt_q + WCNT_W'(1);
          end
          ST_ACCUM: begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= (cnt_q == CNT_LAST) ? '0 : sum_w;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  adc_pipe_sync_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .push_i  (push_w),
    .wdata_i (sum_w),
    .pop_i   (ready_i),
    .rdata_o (data_o),
    .full_o  (full_w),
    .empty_o (empty_w),
    .level_o (level_o)
  );

  assign valid_o    = !empty_w;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_pipe_decimator.sv
// tb_adc_pipe_decimator -- directed checks of the ADC block-sum decimator (OSR_LOG2=3, WARMUP=2, DEPTH=4).
// Rev 1.0
`default_nettype none

module tb_adc_pipe_decimator;

  logic       clock_i = 1'b0;
  logic       reset_ni;
  logic       enable_i;
  logic [2:0] d_i;
  logic [5:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       clear_ovf_i;

  int n_pass  = 0;
  int n_total = 0;

  adc_pipe_decimator #(
    .OSR_LOG2 (3),
    .WARMUP   (2),
    .DEPTH    (4)
  ) dut (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .d_i         (d_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .clear_ovf_i (clear_ovf_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic apply_reset();
    reset_ni    = 1'b0;
    enable_i    = 1'b0;
    ready_i     = 1'b0;
    clear_ovf_i = 1'b0;
    d_i         = 3'd0;
    step();
    step();
    reset_ni    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first;
    reset_ni    = 1'b1;
    enable_i    = 1'b0;
    ready_i     = 1'b0;
    clear_ovf_i = 1'b0;
    d_i         = 3'd0;
    #1 reset_ni = 1'b0;
    #1;
    check_eq("async_reset_valid", valid_o, 0);
    check_eq("async_reset_level", level_o, 0);

    // Constant code 5: first word on edge 10, then every 8 edges.
    apply_reset();
    check_eq("reset_valid", valid_o, 0);
    check_eq("reset_level", level_o, 0);
    check_eq("reset_data", data_o, 0);
    check_eq("reset_ovf", overflow_o, 0);
    enable_i = 1'b1;
    d_i      = 3'd5;
    ready_i  = 1'b1;
    first    = 0;
    for (int e = 1; e <= 30 && first == 0; e++) begin
      step();
      if (valid_o) first = e;
    end
    check_eq("first_valid_edge", first, 10);
    check_eq("first_word", data_o, 40);
    step();
    check_eq("popped_valid", valid_o, 0);
    repeat (6) step();
    check_eq("gap_valid", valid_o, 0);
    step();
    check_eq("second_valid", valid_o, 1);
    check_eq("second_word", data_o, 40);

    // Ramp 0..7 aligned to a block; warmup codes are 7 and must be ignored.
    apply_reset();
    enable_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      d_i = (k >= 3) ? 3'(k - 3) : 3'd7;
      step();
    end
    check_eq("ramp_valid", valid_o, 1);
    check_eq("ramp_word", data_o, 28);
    check_eq("ramp_level", level_o, 1);

    // Fill with 56s, overflow, clear, full push+pop, set-beats-clear, drain.
    apply_reset();
    enable_i = 1'b1;
    d_i      = 3'd7;
    repeat (34) step();
    check_eq("fill_level4", level_o, 4);
    check_eq("fill_no_ovf", overflow_o, 0);
    repeat (8) step();
    check_eq("ovf_level", level_o, 4);
    check_eq("ovf_set", overflow_o, 1);
    check_eq("ovf_head", data_o, 56);
    clear_ovf_i = 1'b1;
    step();
    clear_ovf_i = 1'b0;
    check_eq("ovf_cleared", overflow_o, 0);
    repeat (6) step();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check_eq("full_pushpop_level", level_o, 4);
    check_eq("full_pushpop_ovf", overflow_o, 0);
    check_eq("full_pushpop_head", data_o, 56);
    repeat (7) step();
    clear_ovf_i = 1'b1;
    step();
    clear_ovf_i = 1'b0;
    check_eq("ovf_set_wins", overflow_o, 1);
    enable_i = 1'b0;
    ready_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", valid_o, 1);
      check_eq("drain_word", data_o, 56);
      step();
    end
    check_eq("drained_valid", valid_o, 0);
    check_eq("drained_level", level_o, 0);
    check_eq("drained_ovf_sticky", overflow_o, 1);

    // Disable after 5 ACCUM samples; the partial sum must not leak.
    apply_reset();
    enable_i = 1'b1;
    d_i      = 3'd1;
    ready_i  = 1'b1;
    repeat (7) step();
    enable_i = 1'b0;
    d_i      = 3'd2;
    step();
    check_eq("disable_valid", valid_o, 0);
    enable_i = 1'b1;
    repeat (9) step();
    check_eq("reenable_early", valid_o, 0);
    step();
    check_eq("reenable_valid", valid_o, 1);
    check_eq("reenable_word", data_o, 16);

    // Asynchronous reset mid-period with two words queued.
    apply_reset();
    enable_i = 1'b1;
    d_i      = 3'd3;
    repeat (18) step();
    check_eq("pre_rst_level", level_o, 2);
    check_eq("pre_rst_head", data_o, 24);
    #3 reset_ni = 1'b0;
    #1;
    check_eq("mid_rst_valid", valid_o, 0);
    check_eq("mid_rst_level", level_o, 0);
    check_eq("mid_rst_data", data_o, 0);
    step();
    reset_ni = 1'b1;
    repeat (9) step();
    check_eq("post_rst_early", valid_o, 0);
    step();
    check_eq("post_rst_valid", valid_o, 1);
    check_eq("post_rst_word", data_o, 24);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
